// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, SPI mode constant, byte width and
// a counter-width helper used by the controller and its clock generator.
package spi_pkg;

  // Byte width, shared with the dual_clock_spi_device benches.
  localparam int unsigned SPI_BYTE_W = 8;

  // SPI mode as {CPOL, CPHA}; mode 0 idles SCK low and samples on the rising edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Controller state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_SHIFT   = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

  // Bits needed for a counter that runs 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clock_gen.sv
// SCK generator: counts CLOCKS_PER_HALF_BIT cycles per SCK phase while
// enabled and toggles SCK at the end of each phase. rise/fall are
// combinational one-cycle flags asserted in the cycle whose closing clk edge
// makes SCK rise/fall, so the controller can act on that same edge.
// While disabled, SCK is held at its idle level and the phase count is
// cleared, so every enable starts with a full low phase.
module spi_clock_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_HALF_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned        PHASE_W    = cnt_width(CLOCKS_PER_HALF_BIT);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLOCKS_PER_HALF_BIT - 1);
  localparam logic               SCK_IDLE   = SPI_MODE0[1];

  logic [PHASE_W-1:0] phase_cnt;
  logic               phase_end;

  assign phase_end = en && (phase_cnt == PHASE_LAST);
  assign rise      = phase_end && (sck == SCK_IDLE);
  assign fall      = phase_end && (sck != SCK_IDLE);

  // Phase counter and registered SCK; idle level whenever not enabled.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      phase_cnt <= '0;
      sck       <= SCK_IDLE;
    end else if (phase_end) begin
      phase_cnt <= '0;
      sck       <= ~sck;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 controller (initiator). Sends one byte MSB first per accepted
// start_strobe while capturing the target's reply, optionally keeping CS
// asserted between bytes of a multi-byte command.
//
// Handshake: start_strobe is a one-cycle request accepted on any clk edge
// where ready=1 (IDLE or HOLD); tx_data and keep_cs are captured on that
// edge. Requests while ready=0 are dropped, not queued. release_strobe is
// only meaningful in HOLD; start wins if both arrive together. rx_strobe is
// a one-cycle pulse and rx_data stays valid until the next pulse.
//
// Optional build macro: SPI_CONTROLLER_IDLE_TIMEOUT_EN -- auto-release from
// HOLD after IDLE_TIMEOUT cycles with no start.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_HALF_BIT = 4,
  parameter int unsigned CS_SETUP_CLOCKS     = 4,
  parameter int unsigned CS_HOLD_CLOCKS      = 4
`ifdef SPI_CONTROLLER_IDLE_TIMEOUT_EN
  ,
  parameter int unsigned IDLE_TIMEOUT        = 256
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  start_strobe,
  input  logic                  keep_cs,
  input  logic                  release_strobe,
  output logic                  ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_strobe,
  output logic                  spi_sck,
  output logic                  spi_cs_n,
  output logic                  spi_sdo,
  input  logic                  spi_sdi,
  output state_t                state_dbg
);

  localparam int unsigned        CS_CNT_MAX = (CS_SETUP_CLOCKS > CS_HOLD_CLOCKS) ?
                                              CS_SETUP_CLOCKS : CS_HOLD_CLOCKS;
  localparam int unsigned        CS_CNT_W   = cnt_width(CS_CNT_MAX);
  localparam logic [CS_CNT_W-1:0] SETUP_LAST = CS_CNT_W'(CS_SETUP_CLOCKS - 1);
  localparam logic [CS_CNT_W-1:0] HOLD_LAST  = CS_CNT_W'(CS_HOLD_CLOCKS - 1);
  localparam logic [2:0]          BIT_LAST   = 3'(SPI_BYTE_W - 1);

  state_t                state, next_state;
  logic [CS_CNT_W-1:0]   cs_cnt;
  logic [2:0]            bit_cnt;
  logic [SPI_BYTE_W-1:0] shreg;
  logic                  keep_q;
  logic                  byte_done;
  logic                  sck_rise, sck_fall;
  logic                  last_fall;
  logic                  start_ok;
  logic                  timeout_hit;
  logic                  cs_n_d, ready_d;

  assign state_dbg = state;
  assign start_ok  = start_strobe && ((state == ST_IDLE) || (state == ST_HOLD));
  assign last_fall = (state == ST_SHIFT) && sck_fall && (bit_cnt == BIT_LAST);

  spi_clock_gen #(
    .CLOCKS_PER_HALF_BIT(CLOCKS_PER_HALF_BIT)
  ) u_clock_gen (
    .clk  (clk),
    .reset(reset),
    .en   (state == ST_SHIFT),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

`ifdef SPI_CONTROLLER_IDLE_TIMEOUT_EN
  localparam int unsigned        IDLE_W    = cnt_width(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == ST_HOLD) && (idle_cnt == IDLE_LAST);

  // Idle counter: cleared outside HOLD so it restarts on every HOLD entry.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_HOLD)) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus registered CS_n / ready derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      spi_cs_n <= 1'b1;
      ready    <= 1'b1;
    end else begin
      state    <= next_state;
      spi_cs_n <= cs_n_d;
      ready    <= ready_d;
    end
  end

  // Next-state logic; in HOLD a start beats release and timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start_strobe) next_state = ST_SETUP;
      ST_SETUP:   if (cs_cnt == SETUP_LAST) next_state = ST_SHIFT;
      ST_SHIFT:   if (last_fall) next_state = keep_q ? ST_HOLD : ST_RELEASE;
      ST_HOLD: begin
        if (start_strobe) begin
          next_state = ST_SHIFT;
        end else if (release_strobe || timeout_hit) begin
          next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: if (cs_cnt == HOLD_LAST) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state so CS_n and ready come out of flops.
  always_comb begin
    cs_n_d  = (next_state == ST_IDLE);
    ready_d = (next_state == ST_IDLE) || (next_state == ST_HOLD);
  end

  // CS setup / hold timer: counts only while staying in SETUP or RELEASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_cnt <= '0;
    end else if (((state == ST_SETUP) || (state == ST_RELEASE)) && (next_state == state)) begin
      cs_cnt <= cs_cnt + 1'b1;
    end else begin
      cs_cnt <= '0;
    end
  end

  // Shift datapath: one register serves both directions. SDI enters at the
  // bottom on SCK rise; SDO takes the top bit on SCK fall. The received
  // byte is published the cycle after the last fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      keep_q    <= 1'b0;
      spi_sdo   <= 1'b0;
      byte_done <= 1'b0;
      rx_strobe <= 1'b0;
      rx_data   <= '0;
    end else begin
      byte_done <= last_fall;
      rx_strobe <= byte_done;
      if (byte_done) begin
        rx_data <= shreg;
      end
      if (start_ok) begin
        shreg   <= tx_data;
        keep_q  <= keep_cs;
        spi_sdo <= tx_data[SPI_BYTE_W-1];
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        if (sck_rise) begin
          shreg <= {shreg[SPI_BYTE_W-2:0], spi_sdi};
        end
        if (sck_fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          spi_sdo <= last_fall ? 1'b0 : shreg[SPI_BYTE_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a mode 0 target model drives spi_sdi and
// collects spi_sdo, a scoreboard queue holds the bytes the target is
// expected to return, and byte latency / CS timing are computed from the
// configured clock counts. Define SPI_CONTROLLER_IDLE_TIMEOUT_EN to cover
// the HOLD auto-release build.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int N = 4;
  localparam int S = 4;
  localparam int H = 4;
`ifdef SPI_CONTROLLER_IDLE_TIMEOUT_EN
  localparam int T_IDLE = 16;
`endif
  localparam int LAT_IDLE  = 1 + S + 16 * N;
  localparam int LAT_HOLD  = 1 + 16 * N;
  localparam int LAT_LIMIT = LAT_IDLE + 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] tx_data;
  logic       start_strobe, keep_cs, release_strobe;
  logic       ready, rx_strobe, spi_sck, spi_cs_n, spi_sdo, spi_sdi;
  logic [7:0] rx_data;
  logic [2:0] state_dbg;

  spi_controller #(
    .CLOCKS_PER_HALF_BIT(N),
    .CS_SETUP_CLOCKS    (S),
    .CS_HOLD_CLOCKS     (H)
`ifdef SPI_CONTROLLER_IDLE_TIMEOUT_EN
    ,
    .IDLE_TIMEOUT       (T_IDLE)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .start_strobe  (start_strobe),
    .keep_cs       (keep_cs),
    .release_strobe(release_strobe),
    .ready         (ready),
    .rx_data       (rx_data),
    .rx_strobe     (rx_strobe),
    .spi_sck       (spi_sck),
    .spi_cs_n      (spi_cs_n),
    .spi_sdo       (spi_sdo),
    .spi_sdi       (spi_sdi),
    .state_dbg     (state_dbg)
  );

  // ---------------- target model ----------------
  // Mode 0 target: presents bit 7 before the first rise, next bit after
  // each fall; captures SDO on every rise.
  logic [7:0] slv_byte = 8'h00;
  logic       loopback = 1'b0;
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         strobe_cnt = 0;
  int         cs_rise_cnt = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic [2:0] sdi_idx;

  assign sdi_idx = 3'(7 - (fall_cnt - fall_base));
  assign spi_sdi = loopback ? spi_sdo : slv_byte[sdi_idx];

  always @(negedge spi_sck) fall_cnt <= fall_cnt + 1;
  always @(posedge spi_sck) mosi_sr <= {mosi_sr[6:0], spi_sdo};
  always @(posedge spi_cs_n) cs_rise_cnt <= cs_rise_cnt + 1;
  always @(negedge clk) if (rx_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   in_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One byte: returns at the negedge after rx_strobe (or after release when keep=0).
  task automatic do_byte(input logic [7:0] tx, input logic [7:0] slv, input bit keep,
                         input bit lb, input int pre_wait, input int poke_at);
    int   k;
    int   cs_high_seen;
    bit   got;
    int   exp_lat;
    logic [7:0] exp_rx;
    exp_lat = in_hold ? LAT_HOLD : LAT_IDLE;
    repeat (pre_wait) @(negedge clk);
    @(negedge clk);
    check("ready_at_start", ready, 1);
    loopback = lb;
    slv_byte = slv;
    fall_base = fall_cnt;
    exp_q.push_back(lb ? tx : slv);
    tx_data = tx;
    keep_cs = keep;
    start_strobe = 1'b1;
    @(negedge clk);
    k = 0;
    got = 1'b0;
    cs_high_seen = 0;
    check("cs_low_after_start", spi_cs_n, 0);
    while (k < LAT_LIMIT) begin
      if (rx_strobe === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (spi_cs_n !== 1'b0) cs_high_seen++;
      if (k == poke_at) begin
        start_strobe = 1'b1;
        tx_data = ~tx;
      end else begin
        start_strobe = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start_strobe = 1'b0;
    check("rx_strobe_seen", got, 1);
    check("byte_latency", k, exp_lat);
    check("cs_low_during_byte", cs_high_seen, 0);
    exp_rx = exp_q.pop_front();
    check("rx_data", rx_data, exp_rx);
    check("mosi_byte", mosi_sr, tx);
    @(negedge clk);
    check("rx_strobe_single", rx_strobe, 0);
    in_hold = keep;
    if (!keep) begin
      // CS_n rises H cycles after the last fall, which preceded rx_strobe by one.
      repeat (H - 3) @(negedge clk);
      check("cs_low_in_release", spi_cs_n, 0);
      @(negedge clk);
      check("cs_high_after_release", spi_cs_n, 1);
      check("ready_after_release", ready, 1);
    end else begin
      check("ready_in_hold", ready, 1);
      check("cs_low_in_hold", spi_cs_n, 0);
    end
  endtask

  task automatic do_release();
    @(negedge clk);
    release_strobe = 1'b1;
    @(negedge clk);
    release_strobe = 1'b0;
    check("release_not_ready", ready, 0);
    repeat (H - 1) @(negedge clk);
    check("release_cs_still_low", spi_cs_n, 0);
    @(negedge clk);
    check("release_cs_high", spi_cs_n, 1);
    in_hold = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int snap_strobe, snap_rise;
    logic [7:0] t, s;
    bit kp, lb;
    reset = 1'b1;
    tx_data = 8'h00;
    start_strobe = 1'b0;
    keep_cs = 1'b0;
    release_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sck", spi_sck, 0);
    check("reset_cs_n", spi_cs_n, 1);
    check("reset_sdo", spi_sdo, 0);
    check("reset_ready", ready, 1);
    check("reset_rx_strobe", rx_strobe, 0);
    check("reset_rx_data", rx_data, 8'h00);
    reset = 1'b0;

    // Single byte from IDLE.
    do_byte(8'hA5, 8'h3C, 1'b0, 1'b0, 2, -1);

    // Three-byte command, CS held throughout.
    snap_strobe = strobe_cnt;
    snap_rise = cs_rise_cnt;
    do_byte(8'h05, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 0, -1);
    do_byte(8'h12, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 0, -1);
    check("multi_no_cs_rise", cs_rise_cnt - snap_rise, 0);
    do_byte(8'h34, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 0, -1);
    check("multi_strobes", strobe_cnt - snap_strobe, 3);
    check("multi_one_cs_rise", cs_rise_cnt - snap_rise, 1);

    // Loopback.
    do_byte(8'h00, 8'h5A, 1'b0, 1'b1, 1, -1);
    do_byte(8'hFF, 8'h5A, 1'b0, 1'b1, 1, -1);
    do_byte(8'h81, 8'h5A, 1'b0, 1'b1, 1, -1);

    // release_strobe in IDLE, then start poked during SHIFT: both ignored.
    @(negedge clk);
    release_strobe = 1'b1;
    @(negedge clk);
    release_strobe = 1'b0;
    check("idle_release_cs", spi_cs_n, 1);
    check("idle_release_ready", ready, 1);
    snap_strobe = strobe_cnt;
    snap_rise = cs_rise_cnt;
    do_byte(8'hC3, 8'h96, 1'b0, 1'b0, 1, S + 8 * N + 3);
    repeat (100) @(negedge clk);
    check("poke_one_strobe", strobe_cnt - snap_strobe, 1);
    check("poke_one_cs_rise", cs_rise_cnt - snap_rise, 1);
    check("poke_cs_idle", spi_cs_n, 1);

    // Reset in the middle of bit 4.
    snap_strobe = strobe_cnt;
    @(negedge clk);
    slv_byte = 8'hE7;
    fall_base = fall_cnt;
    tx_data = 8'h7E;
    keep_cs = 1'b1;
    start_strobe = 1'b1;
    @(negedge clk);
    start_strobe = 1'b0;
    repeat (S + 8 * N + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_cs_n", spi_cs_n, 1);
    check("midreset_sck", spi_sck, 0);
    check("midreset_ready", ready, 1);
    check("midreset_sdo", spi_sdo, 0);
    repeat (LAT_LIMIT) @(negedge clk);
    check("midreset_no_strobe", strobe_cnt - snap_strobe, 0);
    in_hold = 1'b0;

    // Random traffic.
    for (int i = 0; i < 10; i++) begin
      t = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      kp = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      do_byte(t, s, kp, lb, $urandom_range(0, 3), -1);
      if (kp && ($urandom_range(0, 2) == 0)) do_release();
    end
    if (in_hold) do_release();
    loopback = 1'b0;

`ifdef SPI_CONTROLLER_IDLE_TIMEOUT_EN
    // No activity in HOLD: auto-release after T_IDLE cycles.
    snap_rise = cs_rise_cnt;
    do_byte(8'h4D, 8'hB2, 1'b1, 1'b0, 1, -1);
    repeat (T_IDLE + H - 3) @(negedge clk);
    check("timeout_cs_low", spi_cs_n, 0);
    @(negedge clk);
    check("timeout_cs_high", spi_cs_n, 1);
    check("timeout_one_rise", cs_rise_cnt - snap_rise, 1);
    in_hold = 1'b0;
    // Start in the expiry cycle wins over the timeout.
    do_byte(8'h2B, 8'hD4, 1'b1, 1'b0, 1, -1);
    snap_rise = cs_rise_cnt;
    do_byte(8'h9E, 8'h61, 1'b1, 1'b0, T_IDLE - 4, -1);
    check("timeout_start_wins", cs_rise_cnt - snap_rise, 0);
    do_release();
`else
    // Without the timeout, HOLD persists.
    do_byte(8'h4D, 8'hB2, 1'b1, 1'b0, 1, -1);
    repeat (300) @(negedge clk);
    check("hold_persists_cs", spi_cs_n, 0);
    check("hold_persists_ready", ready, 1);
    do_release();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
